// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle control FSM for the 5-bit-opcode ISA. Sequences
//               FETCH/DECODE/EXEC/MEM/WB, handshakes with the shared memory
//               port (mem_req/mem_ready) and emits per-state datapath
//               controls. Optional macro MCTRL_PERF_EN adds retire and
//               memory-stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int OP_W        = 5,
  parameter int ALU_W       = 4,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op_code,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal,
  output logic             bus_err
`ifdef MCTRL_PERF_EN
  ,
  output logic [31:0]      instr_count,
  output logic [31:0]      stall_count
`endif
);

  localparam logic [2:0] c_st_fetch  = 3'd0;
  localparam logic [2:0] c_st_decode = 3'd1;
  localparam logic [2:0] c_st_exec   = 3'd2;
  localparam logic [2:0] c_st_mem    = 3'd3;
  localparam logic [2:0] c_st_wb     = 3'd4;
  localparam logic [2:0] c_st_trap   = 3'd5;

  // Opcodes, zero-extended to the opcode width.
  localparam logic [OP_W-1:0] c_op_j    = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] c_op_jal  = OP_W'(5'b00111);
  localparam logic [OP_W-1:0] c_op_rlo  = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] c_op_rhi  = OP_W'(5'b10100);
  localparam logic [OP_W-1:0] c_op_jr   = OP_W'(5'b10010);
  localparam logic [OP_W-1:0] c_op_addi = OP_W'(5'b11000);
  localparam logic [OP_W-1:0] c_op_subi = OP_W'(5'b11001);
  localparam logic [OP_W-1:0] c_op_lw   = OP_W'(5'b11010);
  localparam logic [OP_W-1:0] c_op_sw   = OP_W'(5'b11011);
  localparam logic [OP_W-1:0] c_op_beq  = OP_W'(5'b11100);
  localparam logic [OP_W-1:0] c_op_bne  = OP_W'(5'b11101);

  // Wait counter only needs to reach MEM_TIMEOUT; it saturates instead of wrapping.
  localparam int c_cnt_w = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};
  localparam logic [c_cnt_w-1:0] c_tmo     = c_cnt_w'(MEM_TIMEOUT);

  logic [2:0]         state_q, state_d;
  logic [c_cnt_w-1:0] wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;

  logic               w_is_r, w_is_addi, w_is_subi, w_is_lw, w_is_sw;
  logic               w_is_beq, w_is_bne, w_is_j, w_is_jal, w_is_jr, w_legal;
  logic               w_taken, w_timeout;
  logic [c_cnt_w-1:0] w_wait_inc;
  logic [ALU_W-1:0]   w_r_alu;

  // Opcode classification shared by next-state and output decode.
  always_comb begin
    w_is_r    = (op_code >= c_op_rlo) && (op_code <= c_op_rhi) && (op_code != c_op_jr);
    w_is_addi = (op_code == c_op_addi);
    w_is_subi = (op_code == c_op_subi);
    w_is_lw   = (op_code == c_op_lw);
    w_is_sw   = (op_code == c_op_sw);
    w_is_beq  = (op_code == c_op_beq);
    w_is_bne  = (op_code == c_op_bne);
    w_is_j    = (op_code == c_op_j);
    w_is_jal  = (op_code == c_op_jal);
    w_is_jr   = (op_code == c_op_jr);
    w_legal   = w_is_r | w_is_addi | w_is_subi | w_is_lw | w_is_sw |
                w_is_beq | w_is_bne | w_is_j | w_is_jal | w_is_jr;
    w_taken   = (w_is_beq & zero) | (w_is_bne & ~zero);
    w_r_alu   = ALU_W'(op_code - c_op_rlo);
  end

  // Memory wait bookkeeping: saturating increment and timeout detection.
  always_comb begin
    w_wait_inc = (wait_q == c_cnt_max) ? wait_q : wait_q + c_cnt_w'(1);
    w_timeout  = (MEM_TIMEOUT > 0) && !mem_ready && (w_wait_inc == c_tmo);
  end

  // Next-state, wait counter and sticky error flags.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      c_st_fetch: begin
        if (mem_ready) begin
          state_d = c_st_decode;
        end else if (w_timeout) begin
          state_d   = c_st_trap;
          bus_err_d = 1'b1;
        end else begin
          wait_d = w_wait_inc;
        end
      end
      c_st_decode: begin
        if (w_legal) begin
          state_d = c_st_exec;
        end else begin
          state_d   = c_st_trap;
          illegal_d = 1'b1;
        end
      end
      c_st_exec: begin
        if (w_is_lw || w_is_sw) begin
          state_d = c_st_mem;
          wait_d  = '0;
        end else if (w_is_r || w_is_addi || w_is_subi) begin
          state_d = c_st_wb;
        end else begin
          state_d = c_st_fetch;
          wait_d  = '0;
        end
      end
      c_st_mem: begin
        if (mem_ready) begin
          if (w_is_sw) begin
            state_d = c_st_fetch;
            wait_d  = '0;
          end else begin
            state_d = c_st_wb;
          end
        end else if (w_timeout) begin
          state_d   = c_st_trap;
          bus_err_d = 1'b1;
        end else begin
          wait_d = w_wait_inc;
        end
      end
      c_st_wb: begin
        state_d = c_st_fetch;
        wait_d  = '0;
      end
      c_st_trap: begin
        state_d = c_st_trap;
      end
      default: begin
        state_d = c_st_fetch;
        wait_d  = '0;
      end
    endcase
  end

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= c_st_fetch;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Per-state control decode; everything forced low while reset is held.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    reg_write   = 1'b0;
    reg_dst     = 2'd0;
    wb_sel      = 2'd0;
    alu_src     = 1'b0;
    alu_control = '0;
    case (state_q)
      c_st_fetch: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      c_st_exec: begin
        if (w_is_r) begin
          alu_control = w_r_alu;
        end else if (w_is_addi || w_is_lw || w_is_sw) begin
          alu_src = 1'b1;
        end else if (w_is_subi) begin
          alu_src     = 1'b1;
          alu_control = ALU_W'(1);
        end else if (w_is_beq || w_is_bne) begin
          alu_control = ALU_W'(1);
          pc_write    = w_taken;
          pc_src      = 2'd1;
        end else if (w_is_j) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end else if (w_is_jal) begin
          pc_write  = 1'b1;
          pc_src    = 2'd2;
          reg_write = 1'b1;
          reg_dst   = 2'd2;
          wb_sel    = 2'd2;
        end else if (w_is_jr) begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
        end
      end
      c_st_mem: begin
        mem_req   = 1'b1;
        mem_write = w_is_sw;
      end
      c_st_wb: begin
        reg_write = 1'b1;
        if (w_is_r) begin
          reg_dst = 2'd1;
        end else if (w_is_lw) begin
          wb_sel = 2'd1;
        end
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
    illegal = illegal_q;
    bus_err = bus_err_q;
    if (reset) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'd0;
      reg_write   = 1'b0;
      reg_dst     = 2'd0;
      wb_sel      = 2'd0;
      alu_src     = 1'b0;
      alu_control = '0;
      illegal     = 1'b0;
      bus_err     = 1'b0;
    end
  end

`ifdef MCTRL_PERF_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        w_retire;

  // Retire = leaving EXEC/MEM/WB for FETCH; stall = request pending without ready.
  always_comb begin
    w_retire      = ((state_q == c_st_exec) || (state_q == c_st_mem) || (state_q == c_st_wb)) &&
                    (state_d == c_st_fetch);
    instr_count_d = instr_count_q + (w_retire ? 32'd1 : 32'd0);
    stall_count_d = stall_count_q + ((mem_req && !mem_ready) ? 32'd1 : 32'd0);
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      instr_count_q <= instr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire
